// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter and half-word timing sequencer for a 16-bit asynchronous SRAM
module sram_arbiter #(
    parameter int SRAM_AW = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p0_cmd_valid,
    output logic               p0_cmd_ready,
    input  logic               p0_cmd_write,
    input  logic [SRAM_AW-2:0] p0_cmd_addr,
    input  logic [31:0]        p0_cmd_wdata,
    input  logic [3:0]         p0_cmd_mask,
    output logic               p0_rsp_valid,
    output logic [31:0]        p0_rsp_rdata,
    input  logic               p1_cmd_valid,
    output logic               p1_cmd_ready,
    input  logic               p1_cmd_write,
    input  logic [SRAM_AW-2:0] p1_cmd_addr,
    input  logic [31:0]        p1_cmd_wdata,
    input  logic [3:0]         p1_cmd_mask,
    output logic               p1_rsp_valid,
    output logic [31:0]        p1_rsp_rdata,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_dat_read,
    output logic [15:0]        sram_dat_write,
    output logic               sram_dat_writeEnable,
    output logic               sram_cs,
    output logic               sram_we,
    output logic               sram_oe,
    output logic               sram_lb,
    output logic               sram_ub
);
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;
    state_t state;
    logic last_grant, wr, half;
    logic [SRAM_AW-2:0] addr, in_addr, src_addr;
    logic [31:0] wdata, rdata, in_wdata, src_wdata;
    logic [3:0] mask, cnt, in_mask, src_mask;
    logic [1:0] src_bm;
    logic sel1, grant, in_wr, skip, more, go_setup, src_wr, src_half;

    assign p0_cmd_ready = grant & ~sel1;
    assign p1_cmd_ready = grant & sel1;
    assign p0_rsp_rdata = rdata;
    assign p1_rsp_rdata = rdata;

    // Arbitration (lone requester wins, contention goes to the port that lost last) and next SETUP pin values
    always_comb begin
        sel1 = p1_cmd_valid & (~p0_cmd_valid | ~last_grant);
        grant = (state == IDLE) & (p0_cmd_valid | p1_cmd_valid);
        in_wr = sel1 ? p1_cmd_write : p0_cmd_write;
        in_addr = sel1 ? p1_cmd_addr : p0_cmd_addr;
        in_wdata = sel1 ? p1_cmd_wdata : p0_cmd_wdata;
        in_mask = sel1 ? p1_cmd_mask : p0_cmd_mask;
        skip = in_wr & (in_mask == 4'd0);
        more = ~half & (~wr | (mask[3:2] != 2'd0));
        go_setup = (grant & ~skip) | ((state == HOLD) & more);
        src_wr = (state == IDLE) ? in_wr : wr;
        src_addr = (state == IDLE) ? in_addr : addr;
        src_wdata = (state == IDLE) ? in_wdata : wdata;
        src_mask = (state == IDLE) ? in_mask : mask;
        src_half = (state == IDLE) ? (in_wr & (in_mask[1:0] == 2'd0)) : 1'b1;
        src_bm = src_half ? src_mask[3:2] : src_mask[1:0];
    end

    // Sequencer: every SRAM pin is registered so it is stable for the whole state it belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last_grant <= 1'b1;
            wr <= 1'b0;
            half <= 1'b0;
            addr <= '0;
            wdata <= '0;
            mask <= '0;
            cnt <= '0;
            rdata <= '0;
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            sram_addr <= '0;
            sram_dat_write <= '0;
            sram_dat_writeEnable <= 1'b0;
            sram_cs <= 1'b1;
            sram_we <= 1'b1;
            sram_oe <= 1'b1;
            sram_lb <= 1'b1;
            sram_ub <= 1'b1;
        end else begin
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            case (state)
                IDLE: if (grant) begin
                    wr <= in_wr;
                    addr <= in_addr;
                    wdata <= in_wdata;
                    mask <= in_mask;
                    last_grant <= sel1;
                    state <= skip ? DONE : SETUP;
                    p0_rsp_valid <= skip & ~sel1;
                    p1_rsp_valid <= skip & sel1;
                end
                SETUP: begin
                    state <= ACCESS;
                    cnt <= 4'(WAIT_CYCLES - 1);
                    sram_we <= ~wr;
                end
                ACCESS: if (cnt == 4'd0) begin
                    if (!wr && half) rdata[31:16] <= sram_dat_read;
                    if (!wr && !half) rdata[15:0] <= sram_dat_read;
                    state <= HOLD;
                    sram_we <= 1'b1;
                    sram_oe <= 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                HOLD: begin
                    state <= more ? SETUP : DONE;
                    if (!more) begin
                        p0_rsp_valid <= ~last_grant;
                        p1_rsp_valid <= last_grant;
                        sram_cs <= 1'b1;
                        sram_lb <= 1'b1;
                        sram_ub <= 1'b1;
                        sram_dat_writeEnable <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (go_setup) begin
                half <= src_half;
                sram_addr <= {src_addr, src_half};
                sram_cs <= 1'b0;
                sram_we <= 1'b1;
                sram_oe <= src_wr;
                sram_lb <= src_wr & ~src_bm[0];
                sram_ub <= src_wr & ~src_bm[1];
                sram_dat_writeEnable <= src_wr;
                if (src_wr) sram_dat_write <= src_half ? src_wdata[31:16] : src_wdata[15:0];
            end
        end
    end
endmodule
